// File: rtl/teclado_fifo.sv
// teclado_fifo: synchronised, debounced keypad capture into a FWFT FIFO with overflow flag
module teclado_fifo #(
  parameter int CODE_W   = 4,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int DEB_N    = 4,
  parameter int OUT_MODE = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CODE_W-1:0]        key_code,
  input  logic                     key_da,
  input  logic                     rd,
  input  logic                     clr_ovf,
  output logic [DATA_W-1:0]        out,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     key_pulse,
  output logic                     ovf
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CNW = AW + 1;
  localparam int CW  = $clog2(DEB_N + 1);
  logic              da_s1, da_s2, stable, ev;
  logic [CODE_W-1:0] code_s1, code_s2, ev_code, head;
  logic [CW-1:0]     deb;
  logic [AW-1:0]     wp, rp;
  logic [CODE_W-1:0] mem [DEPTH];
  logic              pop, push, lost;
  assign empty = count == '0;
  assign full  = count == CNW'(DEPTH);
  assign pop   = rd && !empty;
  // a full FIFO still accepts a key when the same edge frees a slot
  assign push  = ev && (!full || pop);
  assign lost  = ev && full && !pop;
  assign head  = mem[rp];
  assign out   = empty ? '0 : (OUT_MODE != 0) ? DATA_W'(1) << head : DATA_W'(head);
  always_ff @(posedge clk) begin
    if (reset) begin
      da_s1     <= 1'b0;
      da_s2     <= 1'b0;
      code_s1   <= '0;
      code_s2   <= '0;
      stable    <= 1'b0;
      deb       <= '0;
      ev        <= 1'b0;
      ev_code   <= '0;
      key_pulse <= 1'b0;
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      ovf       <= 1'b0;
    end else begin
      da_s1     <= key_da;
      da_s2     <= da_s1;
      code_s1   <= key_code;
      code_s2   <= code_s1;
      ev        <= 1'b0;
      // ev marks the rising flip of the stable level; it is consumed one edge later
      if (da_s2 == stable) deb <= '0;
      else if (deb == CW'(DEB_N - 1)) begin
        deb     <= '0;
        stable  <= da_s2;
        ev      <= da_s2;
        ev_code <= code_s2;
      end else deb <= deb + 1'b1;
      key_pulse <= ev;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + CNW'(push) - CNW'(pop);
      ovf   <= lost | (ovf & ~clr_ovf);
    end
  end
  always_ff @(posedge clk) if (push) mem[wp] <= ev_code;
endmodule

// File: doc/teclado_fifo.md
TECLADO_FIFO -- requirements
Module: teclado_fifo

Interface
REQ-001 Parameter CODE_W, 4, width of keypad encoder code bus.
REQ-002 Parameter DATA_W, 32, width of processor read bus.
REQ-003 Parameter DEPTH, 8, FIFO entries; power of 2, >=2.
REQ-004 Parameter DEB_N, 4, consecutive cycles required to accept a data-available change; >=1.
REQ-005 Parameter OUT_MODE, 0, output format: 0 = zero-extended binary, 1 = one-hot (bit[code] set); OUT_MODE=1 requires 2**CODE_W <= DATA_W.
REQ-006 CLK  input  1  system clock (10 MHz nominal); all logic rising-edge.
REQ-007 RESET  input  1  reset, synchronous, active-high.
REQ-008 KEY_CODE  input  CODE_W  asynchronous code from keypad encoder ({D,C,B,A} for CODE_W=4).
REQ-009 KEY_DA  input  1  asynchronous data-available from keypad encoder, active-high.
REQ-010 RD  input  1  processor pop strobe, one cycle per read.
REQ-011 CLR_OVF  input  1  clears the sticky overflow flag.
REQ-012 OUT  output  DATA_W  formatted head-of-FIFO entry.
REQ-013 EMPTY  output  1  FIFO holds no entries.
REQ-014 FULL  output  1  FIFO holds DEPTH entries.
REQ-015 COUNT  output  log2(DEPTH)+1  number of stored entries.
REQ-016 KEY_PULSE  output  1  one-cycle pulse per accepted key press.
REQ-017 OVF  output  1  sticky: a key press was dropped because the FIFO was full.

Function
REQ-018 KEY_DA and KEY_CODE SHALL each pass through a 2-flop synchroniser before any use.
REQ-019 Debounce: the stable level SHALL flip only after the synchronised KEY_DA differs from it on DEB_N consecutive edges; any edge where they match SHALL reset the debounce counter to 0.
REQ-020 A 0->1 flip of the stable level SHALL generate one key event; 1->0 flips SHALL generate none.
REQ-021 Event latency: with KEY_DA first sampled high on edge 0 and held, the stable level SHALL be 1 after edge DEB_N+1; KEY_PULSE SHALL be high and COUNT SHALL have incremented after edge DEB_N+2, for exactly one cycle of KEY_PULSE.
REQ-022 The pushed code SHALL be the synchronised KEY_CODE value present on the edge where the stable level flips to 1.
REQ-023 Push when not full SHALL store the code at the write pointer and increment the write pointer and COUNT.
REQ-024 RD when not empty SHALL discard the head entry and increment the read pointer; RD when empty SHALL be ignored with no state change.
REQ-025 Push and RD on the same edge with FIFO non-empty SHALL both take effect, COUNT unchanged, including when full.
REQ-026 Push when full without RD SHALL drop the code, leave FIFO contents unchanged and set OVF; KEY_PULSE SHALL still assert.
REQ-027 CLR_OVF SHALL clear OVF next edge; if an overflow occurs on the same edge, OVF SHALL remain 1 (set wins).
REQ-028 Pointers SHALL wrap modulo DEPTH; COUNT SHALL never exceed DEPTH or go below 0.
REQ-029 OUT SHALL be first-word-fall-through: it reflects the head entry one cycle after the push into an empty FIFO and the next entry the cycle after RD; OUT SHALL be 0 whenever EMPTY=1.
REQ-030 OUT_MODE=0: OUT = head code zero-extended to DATA_W; OUT_MODE=1: OUT has only bit[head code] set.
REQ-031 EMPTY = (COUNT==0), FULL = (COUNT==DEPTH), both derived from registered COUNT.

Reset
REQ-032 RESET SHALL clear synchronisers, debounce counter, stable level, pointers and OVF; after the reset edge COUNT=0, EMPTY=1, FULL=0, OUT=0, KEY_PULSE=0, OVF=0.
REQ-033 RESET mid-debounce or with entries stored SHALL discard pending event and all entries; RESET SHALL override simultaneous push, RD and CLR_OVF.
REQ-034 KEY_DA held high through reset release SHALL produce one key event DEB_N+2 edges after release.

Verification (CODE_W=4, DATA_W=32, DEPTH=4, DEB_N=4)
REQ-035 KEY_CODE=4'h9, KEY_DA high from edge 0 -> KEY_PULSE high after edge 6 only, COUNT=1, OUT=32'h9 next cycle; OUT_MODE=1 -> OUT=32'h0000_0200.
REQ-036 KEY_DA high for 3 cycles then low -> no KEY_PULSE, COUNT stays 0.
REQ-037 Five presses of 1,2,3,4,5, no RD -> FULL=1, COUNT=4, OVF=1, reads return 1,2,3,4 then EMPTY=1, OUT=0.
REQ-038 FIFO full, press coincides with RD -> COUNT stays 4, OVF stays 0, new code appears last in read order.
REQ-039 RD with EMPTY=1 -> COUNT stays 0, OUT=0; CLR_OVF with OVF=1 -> OVF=0 next cycle.
REQ-040 RESET asserted 2 cycles into debounce with 2 entries stored -> COUNT=0, EMPTY=1, no KEY_PULSE until KEY_DA re-qualifies.
